// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encoding, the NOP bubble word, the PC step and the default reset PC.
// Also holds small PC helper functions used by the fetch unit.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,   // one idle cycle after reset release
        ST_REQ  = 2'd1,   // presenting a fetch request
        ST_WAIT = 2'd2,   // one fetch outstanding, waiting for rvalid
        ST_ERR  = 2'd3    // misaligned redirect target (optional feature)
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // True when a PC is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

    // Forces a PC onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {pc, instr} holding buffer. Catches a fetch response that
// arrives while the downstream stage is stalled, so the response is not lost.
// Priority: clear > load > unload.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load          capture i_pc/i_instr, buffer becomes full
//   i_unload        entry consumed, buffer becomes empty
//   i_clear         discard entry (redirect)
//   i_pc, i_instr   entry to capture
//   o_full          buffer holds an entry
//   o_pc, o_instr   buffered entry
// ---------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_full,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_full;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // Buffer entry and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (i_clear) begin
            r_full  <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_unload) begin
            r_full  <= 1'b0;
        end else begin
            r_full  <= r_full;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the fetch PC, issues one word fetch at a time
// over a req/gnt/rvalid handshake and presents {PC, instruction, valid} to the
// IF/ID stage register. Handles stall (with a one-entry skid buffer), branch
// redirect (with discard of a stale in-flight fetch) and emits a zero
// instruction whenever nothing valid is presented.
//
// Optional feature macro: IF_MISALIGN_CHK_EN
//   defined   : misaligned redirect target raises MisalignErr and parks the
//               unit in ST_ERR until an aligned redirect or reset.
//   undefined : redirect target low bits are forced to 00, MisalignErr = 0.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   Stall          downstream hold, output register frozen
//   Redirect       branch/jump taken, RedirectPC is the new fetch PC
//   IMemReq        fetch request valid (combinational, may assert in the
//                  same cycle as the previous response for back-to-back use)
//   IMemAddr       fetch address (word aligned)
//   IMemGnt        memory accepted the request this cycle
//   IMemRValid     read data valid, in order
//   IMemRData      instruction word
//   PC_out         PC of presented instruction
//   Instr_out      presented instruction, 0 when Valid_out = 0
//   Valid_out      PC_out/Instr_out hold a real instruction
//   MisalignErr    misaligned redirect target seen
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] PC_out,
    output logic [31:0] Instr_out,
    output logic        Valid_out,
    output logic        MisalignErr
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fpc;
    logic [31:0]  w_fpc_nxt;
    logic         r_outstanding;
    logic         w_outstanding_nxt;
    logic         r_drop;
    logic         w_drop_nxt;

    logic [31:0]  r_pc_out;
    logic [31:0]  r_instr_out;
    logic         r_valid_out;
    logic         r_misalign;

    logic [31:0]  w_redir_pc;
    logic         w_redir_bad;
    logic         w_rsp;
    logic         w_keep;
    logic         w_req;
    logic         w_gnt;
    logic [31:0]  w_rsp_pc;

    logic         w_buf_full;
    logic [31:0]  w_buf_pc;
    logic [31:0]  w_buf_instr;
    logic         w_buf_load;
    logic         w_buf_unload;
    logic         w_buf_empty_nxt;

`ifdef IF_MISALIGN_CHK_EN
    assign w_redir_pc  = RedirectPC;
    assign w_redir_bad = is_misaligned(RedirectPC);
`else
    assign w_redir_pc  = align_pc(RedirectPC);
    assign w_redir_bad = 1'b0;
`endif

    // A response only counts while a fetch is outstanding; late data after
    // reset is ignored because the outstanding flag is cleared.
    assign w_rsp    = IMemRValid & r_outstanding;
    // Response that actually reaches the pipeline (not stale, not overridden).
    assign w_keep   = w_rsp & ~r_drop & ~Redirect;
    // fpc was already advanced on grant, so the response belongs to fpc-4.
    assign w_rsp_pc = r_fpc - PC_INC;

    assign w_buf_load      = w_keep & Stall;
    assign w_buf_unload    = ~Redirect & ~Stall & w_buf_full;
    assign w_buf_empty_nxt = w_buf_full ? ~Stall : ~w_buf_load;

    // Request generation: in WAIT a new request may go out in the same cycle
    // as the response, which sustains one instruction per cycle.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_REQ:  w_req = ~w_buf_full;
            ST_WAIT: w_req = w_keep & w_buf_empty_nxt;
            default: w_req = 1'b0;
        endcase
    end

    assign w_gnt             = w_req & IMemGnt;
    assign w_outstanding_nxt = (r_outstanding & ~w_rsp) | w_gnt;

    // Next-state, next fetch PC and drop flag.
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_drop_nxt  = r_drop;
        if (Redirect) begin
            w_fpc_nxt  = w_redir_pc;
            // Anything still in flight after this edge belongs to the old path.
            w_drop_nxt = w_outstanding_nxt;
            if (w_redir_bad) begin
                w_state_nxt = ST_ERR;
            end else if (w_outstanding_nxt) begin
                w_state_nxt = ST_WAIT;
            end else begin
                w_state_nxt = ST_REQ;
            end
        end else begin
            if (w_gnt) begin
                w_fpc_nxt = r_fpc + PC_INC;
            end else begin
                w_fpc_nxt = r_fpc;
            end
            if (w_rsp) begin
                w_drop_nxt = 1'b0;
            end else begin
                w_drop_nxt = r_drop;
            end
            case (r_state)
                ST_BOOT: w_state_nxt = ST_REQ;
                ST_REQ:  w_state_nxt = w_gnt ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (w_rsp) begin
                        w_state_nxt = w_gnt ? ST_WAIT : ST_REQ;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_ERR:  w_state_nxt = ST_ERR;
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // Fetch FSM state, fetch PC and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_fpc         <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fpc         <= w_fpc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // Misaligned-target flag: updated on every redirect, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (Redirect) begin
            r_misalign <= w_redir_bad;
        end else begin
            r_misalign <= r_misalign;
        end
    end

    // IF/ID output register: redirect flushes, stall holds, buffered entry
    // has precedence over fresh data, otherwise a bubble is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_out    <= 32'h0000_0000;
            r_instr_out <= NOP_INSTR;
            r_valid_out <= 1'b0;
        end else if (Redirect) begin
            r_pc_out    <= 32'h0000_0000;
            r_instr_out <= NOP_INSTR;
            r_valid_out <= 1'b0;
        end else if (Stall) begin
            r_pc_out    <= r_pc_out;
            r_instr_out <= r_instr_out;
            r_valid_out <= r_valid_out;
        end else if (w_buf_full) begin
            r_pc_out    <= w_buf_pc;
            r_instr_out <= w_buf_instr;
            r_valid_out <= 1'b1;
        end else if (w_keep) begin
            r_pc_out    <= w_rsp_pc;
            r_instr_out <= IMemRData;
            r_valid_out <= 1'b1;
        end else begin
            r_pc_out    <= r_pc_out;
            r_instr_out <= NOP_INSTR;
            r_valid_out <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_buf_load),
        .i_unload (w_buf_unload),
        .i_clear  (Redirect),
        .i_pc     (w_rsp_pc),
        .i_instr  (IMemRData),
        .o_full   (w_buf_full),
        .o_pc     (w_buf_pc),
        .o_instr  (w_buf_instr)
    );

    assign IMemReq     = w_req;
    assign IMemAddr    = r_fpc;
    assign PC_out      = r_pc_out;
    assign Instr_out   = r_instr_out;
    assign Valid_out   = r_valid_out;
    assign MisalignErr = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A second instance with a reset PC near
// the top of the address space checks PC wrap-around. Memory returns
// 32'h1000_0000 + address with configurable grant probability and latency.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall, Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt, IMemRValid;
    logic [31:0] IMemRData;
    logic [31:0] PC_out, Instr_out;
    logic        Valid_out, MisalignErr;

    logic        Stall2, Redirect2;
    logic [31:0] RedirectPC2;
    logic        IMemReq2;
    logic [31:0] IMemAddr2;
    logic        IMemGnt2, IMemRValid2;
    logic [31:0] IMemRData2;
    logic [31:0] PC2, Instr2;
    logic        Valid2, MisalignErr2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt), .IMemRValid(IMemRValid),
        .IMemRData(IMemRData), .PC_out(PC_out), .Instr_out(Instr_out), .Valid_out(Valid_out),
        .MisalignErr(MisalignErr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .Stall(Stall2), .Redirect(Redirect2), .RedirectPC(RedirectPC2),
        .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemGnt(IMemGnt2), .IMemRValid(IMemRValid2),
        .IMemRData(IMemRData2), .PC_out(PC2), .Instr_out(Instr2), .Valid_out(Valid2),
        .MisalignErr(MisalignErr2)
    );

    int checks = 0;
    int failures = 0;

    // memory model state (one fetch may be pending)
    bit          pend_v = 1'b0;
    logic [31:0] pend_a = 32'h0;
    int          pend_c = 0;
    int          lat_lo = 1, lat_hi = 1, gnt_pct = 100;
    bit          last_req, last_gnt;
    logic [31:0] last_addr;
    bit          pend2_v = 1'b0;
    logic [31:0] pend2_a = 32'h0;
    bit          collect2 = 1'b0;
    logic [31:0] q2[$];

    typedef struct {
        logic        st;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    function automatic vec_t mkvec(input logic st, input logic rq, input logic [31:0] ad,
                                   input logic v, input logic [31:0] pc);
        vec_t r;
        r.st = st; r.exp_req = rq; r.exp_addr = ad; r.exp_v = v; r.exp_pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, respond to requests, advance.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        logic        r2;
        logic [31:0] a2;
        Stall = st; Redirect = rd; RedirectPC = rpc;
        if (pend_v && pend_c == 1) begin
            IMemRValid = 1'b1; IMemRData = memf(pend_a);
        end else begin
            IMemRValid = 1'b0; IMemRData = $urandom;
        end
        IMemRValid2 = pend2_v; IMemRData2 = memf(pend2_a);
        IMemGnt = ($urandom_range(1, 100) <= gnt_pct) ? 1'b1 : 1'b0;
        #1;
        last_req = IMemReq; last_addr = IMemAddr; last_gnt = IMemReq & IMemGnt;
        r2 = IMemReq2; a2 = IMemAddr2;
        if (IMemReq) chk("addr_align", {30'd0, IMemAddr[1:0]}, 32'd0);
        @(posedge clk);
        if (pend_v) begin
            if (pend_c == 1) pend_v = 1'b0;
            else pend_c--;
        end
        if (last_gnt && !rst) begin
            chk("one_outstanding", {31'd0, pend_v}, 32'd0);
            pend_v = 1'b1; pend_a = last_addr; pend_c = $urandom_range(lat_lo, lat_hi);
        end
        pend2_v = r2 & ~rst; pend2_a = a2;
        @(negedge clk);
        if (collect2 && Valid2 && q2.size() < 3) q2.push_back(PC2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    endtask

    // Ticks until Valid_out, then checks the presented PC and instruction.
    task automatic wait_valid(input string name, input logic [31:0] pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            seen = Valid_out;
        end
        chk({name, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({name, "_pc"}, PC_out, pc);
            chk({name, "_instr"}, Instr_out, memf(pc));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        pv, st, rd;
        logic [31:0] ppc, pin, rpc, exp_pc;
        int          delivered;

        rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;
        Stall2 = 1'b0; Redirect2 = 1'b0; RedirectPC2 = 32'h0;
        IMemGnt2 = 1'b1; IMemRValid2 = 1'b0; IMemRData2 = 32'h0;

        // zero-wait streaming with a 3-cycle stall (inputs, expected outputs)
        tbl[0]  = mkvec(1'b0, 1'b0, 32'h00, 1'b0, 32'h00);
        tbl[1]  = mkvec(1'b0, 1'b1, 32'h00, 1'b0, 32'h00);
        tbl[2]  = mkvec(1'b0, 1'b1, 32'h04, 1'b1, 32'h00);
        tbl[3]  = mkvec(1'b0, 1'b1, 32'h08, 1'b1, 32'h04);
        tbl[4]  = mkvec(1'b0, 1'b1, 32'h0C, 1'b1, 32'h08);
        tbl[5]  = mkvec(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[6]  = mkvec(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[7]  = mkvec(1'b1, 1'b0, 32'h00, 1'b1, 32'h08);
        tbl[8]  = mkvec(1'b0, 1'b0, 32'h00, 1'b1, 32'h0C);
        tbl[9]  = mkvec(1'b0, 1'b1, 32'h10, 1'b0, 32'h00);
        tbl[10] = mkvec(1'b0, 1'b1, 32'h14, 1'b1, 32'h10);
        tbl[11] = mkvec(1'b0, 1'b1, 32'h18, 1'b1, 32'h14);

        @(negedge clk);
        collect2 = 1'b1;
        do_reset();
        chk("rst_req", {31'd0, IMemReq}, 32'd0);
        chk("rst_addr", IMemAddr, 32'h0);
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_instr", Instr_out, 32'h0);
        chk("rst_valid", {31'd0, Valid_out}, 32'd0);
        chk("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        chk("rst_addr_wrapdut", IMemAddr2, 32'hFFFF_FFF8);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].st, 1'b0, 32'h0);
            chk($sformatf("row%0d_req", i), {31'd0, last_req}, {31'd0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("row%0d_addr", i), last_addr, tbl[i].exp_addr);
            chk($sformatf("row%0d_valid", i), {31'd0, Valid_out}, {31'd0, tbl[i].exp_v});
            if (tbl[i].exp_v) begin
                chk($sformatf("row%0d_pc", i), PC_out, tbl[i].exp_pc);
                chk($sformatf("row%0d_instr", i), Instr_out, memf(tbl[i].exp_pc));
            end else begin
                chk($sformatf("row%0d_instr0", i), Instr_out, 32'h0);
            end
        end

        collect2 = 1'b0;
        chk("wrap_count", q2.size(), 32'd3);
        if (q2.size() == 3) begin
            chk("wrap_pc0", q2[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", q2[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", q2[2], 32'h0000_0000);
        end

        // redirect while a slow fetch is outstanding
        lat_lo = 3; lat_hi = 3;
        do_reset(); rst = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0400);
        chk("redir_valid0", {31'd0, Valid_out}, 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("redir_noreq_in_drop", {31'd0, last_req}, 32'd0);
        lat_lo = 1; lat_hi = 1;
        tick(1'b0, 1'b0, 32'h0);
        chk("redir_req_after_drop", {31'd0, last_req}, 32'd1);
        chk("redir_req_addr", last_addr, 32'h0000_0400);
        wait_valid("redir", 32'h0000_0400);

        // redirect, stall and response in the same cycle
        do_reset(); rst = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h0000_0800);
        chk("rsr_valid0", {31'd0, Valid_out}, 32'd0);
        chk("rsr_instr0", Instr_out, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("rsr_req", {31'd0, last_req}, 32'd1);
        chk("rsr_req_addr", last_addr, 32'h0000_0800);
        chk("rsr_buf_empty", {31'd0, Valid_out}, 32'd0);
        wait_valid("rsr", 32'h0000_0800);

`ifdef IF_MISALIGN_CHK_EN
        do_reset(); rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0402);
        chk("mis_err_set", {31'd0, MisalignErr}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk("mis_noreq", {31'd0, last_req}, 32'd0);
            chk("mis_invalid", {31'd0, Valid_out}, 32'd0);
            chk("mis_err_held", {31'd0, MisalignErr}, 32'd1);
        end
        tick(1'b0, 1'b1, 32'h0000_0500);
        chk("mis_err_clr", {31'd0, MisalignErr}, 32'd0);
        wait_valid("mis_resume", 32'h0000_0500);
`endif

        // randomized traffic against an in-order stream model
        gnt_pct = 70; lat_lo = 1; lat_hi = 3;
        do_reset(); rst = 1'b0;
        exp_pc = 32'h0; delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            st  = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
            rd  = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
`ifdef IF_MISALIGN_CHK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            pv = Valid_out; ppc = PC_out; pin = Instr_out;
            tick(st, rd, rpc);
            if (rd) begin
                chk("rnd_redir_valid", {31'd0, Valid_out}, 32'd0);
                chk("rnd_redir_instr", Instr_out, 32'h0);
                exp_pc = rpc & 32'hFFFF_FFFC;
            end else if (st) begin
                chk("rnd_stall_valid", {31'd0, Valid_out}, {31'd0, pv});
                chk("rnd_stall_pc", PC_out, ppc);
                chk("rnd_stall_instr", Instr_out, pin);
            end else if (Valid_out) begin
                chk("rnd_pc", PC_out, exp_pc);
                chk("rnd_instr", Instr_out, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                chk("rnd_bubble_instr", Instr_out, 32'h0);
            end
        end
        chk("rnd_progress", {31'd0, (delivered > 150) ? 1'b1 : 1'b0}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
